// File: rtl/ysyx_25030085_regfile_sb_pkg.sv
// rtl/ysyx_25030085_regfile_sb_pkg.sv - shared types and default sizes for the scoreboarded register file
package ysyx_25030085_regfile_sb_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_NREG = 32;
  localparam int DEF_NRP  = 2;

  // Register dump stream state
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DUMP = 1'b1
  } dump_state_t;

endpackage

// File: rtl/ysyx_25030085_rf_rdport.sv
// rtl/ysyx_25030085_rf_rdport.sv - one combinational read port with write/load-return bypass
module ysyx_25030085_rf_rdport
  import ysyx_25030085_regfile_sb_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  localparam int AW  = $clog2(NREG)
) (
  input  logic [AW-1:0]   idx,
  input  logic [XLEN-1:0] regs [NREG],
  input  logic [NREG-1:0] pending,
  input  logic            wr_fire,
  input  logic [AW-1:0]   wr_rd,
  input  logic [XLEN-1:0] wr_data,
  input  logic            ld_rsp_valid,
  input  logic [AW-1:0]   ld_rsp_rd,
  input  logic [XLEN-1:0] ld_rsp_data,
  output logic [XLEN-1:0] data,
  output logic            busy
);

  logic is_x0;
  logic wr_hit;
  logic rsp_hit;

  assign is_x0   = (idx == '0);
  assign wr_hit  = wr_fire && (wr_rd == idx);
  assign rsp_hit = ld_rsp_valid && (ld_rsp_rd == idx);

  // Data select: x0 is hardwired zero, then this cycle's write, then the load return, then the array
  always_comb begin
    data = '0;
    if (!is_x0) begin
      if (wr_hit) begin
        data = wr_data;
      end else if (rsp_hit) begin
        data = ld_rsp_data;
      end else begin
        data = regs[idx];
      end
    end
  end

  // A register whose load result is arriving this cycle is no longer busy to the reader
  always_comb begin
    busy = 1'b0;
    if (!is_x0) begin
      busy = pending[idx] && !rsp_hit;
    end
  end

endmodule

// File: rtl/ysyx_25030085_regfile_sb.sv
// rtl/ysyx_25030085_regfile_sb.sv - register file with load scoreboard, bypassed read ports and dump stream
module ysyx_25030085_regfile_sb
  import ysyx_25030085_regfile_sb_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  parameter int NRP  = DEF_NRP,
  localparam int AW  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRP*AW-1:0] rs_idx,
  output logic [NRP*XLEN-1:0] rs_data,
  output logic [NRP-1:0]    rs_busy,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [AW-1:0]     wr_rd,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              ld_iss_valid,
  output logic              ld_iss_ready,
  input  logic [AW-1:0]     ld_iss_rd,
  input  logic              ld_rsp_valid,
  input  logic [AW-1:0]     ld_rsp_rd,
  input  logic [XLEN-1:0]   ld_rsp_data,
  output logic              err,
  input  logic              dbg_req,
  output logic              dbg_busy,
  output logic              dbg_valid,
  output logic [AW-1:0]     dbg_idx,
  output logic [XLEN-1:0]   dbg_data
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_next;
  logic            wr_fire;
  logic            ld_iss_fire;

  dump_state_t     state;
  dump_state_t     state_next;
  logic [AW-1:0]   cnt;
  logic [AW-1:0]   cnt_next;

  // Handshakes look only at the registered scoreboard, so there is no path from responses to ready
  assign wr_ready     = !pending[wr_rd];
  assign ld_iss_ready = !pending[ld_iss_rd];
  assign wr_fire      = wr_valid && wr_ready;
  assign ld_iss_fire  = ld_iss_valid && ld_iss_ready;

  // Array update: the write channel is applied after the load return so it wins a same-rd collision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (ld_rsp_valid && (ld_rsp_rd != '0)) begin
        regs[ld_rsp_rd] <= ld_rsp_data;
      end
      if (wr_fire && (wr_rd != '0)) begin
        regs[wr_rd] <= wr_data;
      end
    end
  end

  // Scoreboard next value: a response clears, an issue in the same cycle sets again; x0 never pends
  always_comb begin
    pending_next = pending;
    if (ld_rsp_valid) begin
      pending_next[ld_rsp_rd] = 1'b0;
    end
    if (ld_iss_fire) begin
      pending_next[ld_iss_rd] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  // Scoreboard register and sticky error for a response to a register with no outstanding load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      err     <= 1'b0;
    end else begin
      pending <= pending_next;
      if (ld_rsp_valid && !pending[ld_rsp_rd]) begin
        err <= 1'b1;
      end
    end
  end

  // One bypassed read port per requested source operand
  for (genvar p = 0; p < NRP; p++) begin : g_rdport
    ysyx_25030085_rf_rdport #(
      .XLEN (XLEN),
      .NREG (NREG)
    ) u_rdport (
      .idx          (rs_idx[p*AW +: AW]),
      .regs         (regs),
      .pending      (pending),
      .wr_fire      (wr_fire),
      .wr_rd        (wr_rd),
      .wr_data      (wr_data),
      .ld_rsp_valid (ld_rsp_valid),
      .ld_rsp_rd    (ld_rsp_rd),
      .ld_rsp_data  (ld_rsp_data),
      .data         (rs_data[p*XLEN +: XLEN]),
      .busy         (rs_busy[p])
    );
  end

  // Dump FSM state and beat counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Dump FSM next state: requests are only honoured from IDLE, so mid-dump and last-beat requests drop
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    dbg_valid  = 1'b0;
    dbg_busy   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dbg_req) begin
          state_next = ST_DUMP;
          cnt_next   = '0;
        end
      end
      ST_DUMP: begin
        dbg_valid = 1'b1;
        dbg_busy  = 1'b1;
        if (cnt == AW'(NREG - 1)) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + AW'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign dbg_idx = dbg_valid ? cnt : '0;

  // Dumped value is what the register holds after this cycle's edge, so same-cycle updates are forwarded
  always_comb begin
    dbg_data = '0;
    if ((state == ST_DUMP) && (cnt != '0)) begin
      if (wr_fire && (wr_rd == cnt)) begin
        dbg_data = wr_data;
      end else if (ld_rsp_valid && (ld_rsp_rd == cnt)) begin
        dbg_data = ld_rsp_data;
      end else begin
        dbg_data = regs[cnt];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25030085_regfile_sb.sv
// tb/tb_ysyx_25030085_regfile_sb.sv - directed self-checking bench for the scoreboarded register file
module tb_ysyx_25030085_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRP  = 2;
  localparam int AW   = 5;

  logic              clk;
  logic              rst;
  logic [NRP*AW-1:0] rs_idx;
  logic [NRP*XLEN-1:0] rs_data;
  logic [NRP-1:0]    rs_busy;
  logic              wr_valid;
  logic              wr_ready;
  logic [AW-1:0]     wr_rd;
  logic [XLEN-1:0]   wr_data;
  logic              ld_iss_valid;
  logic              ld_iss_ready;
  logic [AW-1:0]     ld_iss_rd;
  logic              ld_rsp_valid;
  logic [AW-1:0]     ld_rsp_rd;
  logic [XLEN-1:0]   ld_rsp_data;
  logic              err;
  logic              dbg_req;
  logic              dbg_busy;
  logic              dbg_valid;
  logic [AW-1:0]     dbg_idx;
  logic [XLEN-1:0]   dbg_data;

  int n_cmp;
  int n_bad;

  ysyx_25030085_regfile_sb #(
    .XLEN (XLEN),
    .NREG (NREG),
    .NRP  (NRP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rs_idx       (rs_idx),
    .rs_data      (rs_data),
    .rs_busy      (rs_busy),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_rd        (wr_rd),
    .wr_data      (wr_data),
    .ld_iss_valid (ld_iss_valid),
    .ld_iss_ready (ld_iss_ready),
    .ld_iss_rd    (ld_iss_rd),
    .ld_rsp_valid (ld_rsp_valid),
    .ld_rsp_rd    (ld_rsp_rd),
    .ld_rsp_data  (ld_rsp_data),
    .err          (err),
    .dbg_req      (dbg_req),
    .dbg_busy     (dbg_busy),
    .dbg_valid    (dbg_valid),
    .dbg_idx      (dbg_idx),
    .dbg_data     (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [XLEN-1:0] fill_val(input int i);
    return (i == 0) ? 32'h0 : (32'hA000_0000 | 32'(i));
  endfunction

  initial begin
    logic [XLEN-1:0] exp_d;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    rs_idx = '0;
    wr_valid = 1'b0; wr_rd = '0; wr_data = '0;
    ld_iss_valid = 1'b0; ld_iss_rd = '0;
    ld_rsp_valid = 1'b0; ld_rsp_rd = '0; ld_rsp_data = '0;
    dbg_req = 1'b0;

    // Reset state
    #3;
    check("rst_dbg_valid", 64'(dbg_valid), 64'd0);
    check("rst_dbg_busy", 64'(dbg_busy), 64'd0);
    check("rst_dbg_idx", 64'(dbg_idx), 64'd0);
    check("rst_dbg_data", 64'(dbg_data), 64'd0);
    check("rst_wr_ready", 64'(wr_ready), 64'd1);
    check("rst_ld_iss_ready", 64'(ld_iss_ready), 64'd1);
    check("rst_err", 64'(err), 64'd0);
    step();
    rst = 1'b1;
    step();

    // Forwarding of a fired write in the same cycle
    wr_valid = 1'b1; wr_rd = 5'd5; wr_data = 32'hDEAD_BEEF;
    rs_idx = {5'd5, 5'd5};
    #2;
    check("fwd_wr_ready", 64'(wr_ready), 64'd1);
    check("fwd_rs0", 64'(rs_data[31:0]), 64'hDEAD_BEEF);
    check("fwd_rs1", 64'(rs_data[63:32]), 64'hDEAD_BEEF);
    step();
    wr_valid = 1'b0;
    #2;
    check("fwd_array", 64'(rs_data[31:0]), 64'hDEAD_BEEF);

    // Load pending blocks a WAW write until the response
    ld_iss_valid = 1'b1; ld_iss_rd = 5'd7;
    rs_idx = {5'd7, 5'd5};
    #2;
    check("ld_iss_ready7", 64'(ld_iss_ready), 64'd1);
    step();
    ld_iss_valid = 1'b0;
    wr_valid = 1'b1; wr_rd = 5'd7; wr_data = 32'h0000_AAAA;
    for (int c = 0; c < 3; c++) begin
      #2;
      check("pend_wr_ready", 64'(wr_ready), 64'd0);
      check("pend_busy1", 64'(rs_busy[1]), 64'd1);
      check("pend_iss_ready", 64'(ld_iss_ready), 64'd0);
      step();
    end
    ld_rsp_valid = 1'b1; ld_rsp_rd = 5'd7; ld_rsp_data = 32'h1234_5678;
    #2;
    check("rsp_busy1", 64'(rs_busy[1]), 64'd0);
    check("rsp_rs1", 64'(rs_data[63:32]), 64'h1234_5678);
    check("rsp_wr_ready", 64'(wr_ready), 64'd0);
    step();
    ld_rsp_valid = 1'b0;
    #2;
    check("post_wr_ready", 64'(wr_ready), 64'd1);
    check("post_rs1_fwd", 64'(rs_data[63:32]), 64'h0000_AAAA);
    step();
    wr_valid = 1'b0;
    #2;
    check("post_rs1_arr", 64'(rs_data[63:32]), 64'h0000_AAAA);
    check("post_err", 64'(err), 64'd0);

    // Response to a non-pending register: written and sticky error
    ld_rsp_valid = 1'b1; ld_rsp_rd = 5'd9; ld_rsp_data = 32'h0000_9999;
    rs_idx = {5'd7, 5'd9};
    #2;
    check("err_pre", 64'(err), 64'd0);
    check("err_bypass", 64'(rs_data[31:0]), 64'h0000_9999);
    step();
    ld_rsp_valid = 1'b0;
    #2;
    check("err_set", 64'(err), 64'd1);
    check("err_x9", 64'(rs_data[31:0]), 64'h0000_9999);
    step(); step(); step();
    check("err_hold", 64'(err), 64'd1);

    // Same-cycle issue and response on x3 leaves it pending
    ld_iss_valid = 1'b1; ld_iss_rd = 5'd3;
    ld_rsp_valid = 1'b1; ld_rsp_rd = 5'd3; ld_rsp_data = 32'h0000_0033;
    rs_idx = {5'd7, 5'd3};
    #2;
    check("same_iss_ready", 64'(ld_iss_ready), 64'd1);
    check("same_busy_now", 64'(rs_busy[0]), 64'd0);
    step();
    ld_iss_valid = 1'b0; ld_rsp_valid = 1'b0;
    #2;
    check("same_busy_next", 64'(rs_busy[0]), 64'd1);
    check("same_x3", 64'(rs_data[31:0]), 64'h0000_0033);
    ld_rsp_valid = 1'b1; ld_rsp_data = 32'h0000_0034;
    #1;
    check("same_clr_busy", 64'(rs_busy[0]), 64'd0);
    check("same_clr_data", 64'(rs_data[31:0]), 64'h0000_0034);
    step();
    ld_rsp_valid = 1'b0;
    #2;
    check("same_clr_after", 64'(rs_busy[0]), 64'd0);

    // x0 ignores writes and load issues
    wr_valid = 1'b1; wr_rd = 5'd0; wr_data = 32'hFFFF_FFFF;
    ld_iss_valid = 1'b1; ld_iss_rd = 5'd0;
    rs_idx = {5'd0, 5'd0};
    #2;
    check("x0_rd_now", 64'(rs_data[31:0]), 64'd0);
    check("x0_busy_now", 64'(rs_busy[0]), 64'd0);
    check("x0_iss_ready", 64'(ld_iss_ready), 64'd1);
    step();
    wr_valid = 1'b0; ld_iss_valid = 1'b0;
    #2;
    check("x0_rd_after", 64'(rs_data[63:32]), 64'd0);
    check("x0_busy_after", 64'(rs_busy[1]), 64'd0);
    check("x0_wr_ready", 64'(wr_ready), 64'd1);

    // Reset clears array and error asynchronously
    rs_idx = {5'd3, 5'd5};
    rst = 1'b0;
    #1;
    check("rst2_err", 64'(err), 64'd0);
    check("rst2_x5", 64'(rs_data[31:0]), 64'd0);
    check("rst2_x3_busy", 64'(rs_busy[1]), 64'd0);
    step();
    rst = 1'b1;
    step();

    // Fill registers with known values
    for (int i = 1; i < NREG; i++) begin
      wr_valid = 1'b1; wr_rd = AW'(i); wr_data = fill_val(i);
      step();
    end
    wr_valid = 1'b0;

    // Full dump with ignored requests at beat 10 and the final beat
    dbg_req = 1'b1;
    #2;
    check("dump_idle_valid", 64'(dbg_valid), 64'd0);
    step();
    dbg_req = 1'b0;
    for (int b = 0; b < NREG; b++) begin
      wr_valid = (b == 5);
      wr_rd = 5'd12; wr_data = 32'hCAFE_0012;
      dbg_req = (b == 10) || (b == NREG - 1);
      exp_d = (b == 12) ? 32'hCAFE_0012 : fill_val(b);
      #2;
      check("dump_valid", 64'(dbg_valid), 64'd1);
      check("dump_busy", 64'(dbg_busy), 64'd1);
      check("dump_idx", 64'(dbg_idx), 64'(b));
      check("dump_data", 64'(dbg_data), 64'(exp_d));
      step();
    end
    wr_valid = 1'b0; dbg_req = 1'b0;
    #2;
    check("dump_end_valid", 64'(dbg_valid), 64'd0);
    check("dump_end_busy", 64'(dbg_busy), 64'd0);
    step();
    check("dump_end_valid2", 64'(dbg_valid), 64'd0);

    // Second dump aborted by reset at beat 20
    dbg_req = 1'b1;
    step();
    dbg_req = 1'b0;
    for (int b = 0; b <= 20; b++) begin
      #2;
      check("abort_idx", 64'(dbg_idx), 64'(b));
      if (b < 20) step();
    end
    rst = 1'b0;
    #1;
    check("abort_valid", 64'(dbg_valid), 64'd0);
    check("abort_busy", 64'(dbg_busy), 64'd0);
    check("abort_idx0", 64'(dbg_idx), 64'd0);
    check("abort_data0", 64'(dbg_data), 64'd0);
    step(); step();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("abort_quiet", 64'(dbg_valid), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
